// File: rtl/ik_swift_hps_st_channel_arbiter_if.sv
// Avalon-ST fan-in bundle for the HPS packet channel arbiter: NUM_IN source
// streams in, one channel-tagged stream out, plus status.
interface ik_swift_hps_st_channel_arbiter_if #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CHAN_W = 8
);
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_startofpacket;
  logic [NUM_IN-1:0]        in_endofpacket;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHAN_W-1:0]        out_channel;
  logic                     busy;
  logic                     err_sop;

  // Environment side: drives the sources and downstream ready.
  modport master (
    output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
    input  out_channel, busy, err_sop
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
    output out_channel, busy, err_sop
  );
endinterface

// File: rtl/ik_swift_hps_st_channel_arbiter.sv
// Packet-atomic round-robin arbiter: locks a grant for a whole packet and
// forwards granted beats through one registered stage tagged with the source.
module ik_swift_hps_st_channel_arbiter #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CHAN_W = 8
) (
  input logic                              clk,
  input logic                              reset_n,
  ik_swift_hps_st_channel_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  idx_t              grant_q, grant_d;
  idx_t              last_grant_q, last_grant_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  idx_t              chan_q, chan_d;

  logic [NUM_IN-1:0] in_ready;
  logic              err_sop;
  logic              load;
  logic              stage_free;
  idx_t              winner;
  logic [DATA_W-1:0] in_data_arr [NUM_IN];

  // First requester after 'last', wrapping around.
  function automatic idx_t rr_pick(input logic [NUM_IN-1:0] req, input idx_t last);
    idx_t        pick;
    idx_t        cand;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      idx  = (32'(last) + k) % NUM_IN;
      cand = idx_t'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return pick;
  endfunction

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
    assign in_data_arr[gi] = bus.in_data[gi*DATA_W +: DATA_W];
  end

  assign winner     = rr_pick(bus.in_valid, last_grant_q);
  assign stage_free = !out_valid_q || bus.out_ready;

  // Arbitration / packet-lock next state and per-source ready.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in_ready     = '0;
    err_sop      = 1'b0;
    load         = 1'b0;
    case (state_q)
      StIdle: begin
        if (|bus.in_valid) begin
          if (bus.in_startofpacket[winner]) begin
            grant_d = winner;
            state_d = StBusy;
          end else begin
            // Orphan mid-packet beat: swallow it and move the pointer on.
            in_ready[winner] = 1'b1;
            err_sop          = 1'b1;
            last_grant_d     = winner;
          end
        end
      end
      StBusy: begin
        in_ready[grant_q] = stage_free;
        if (bus.in_valid[grant_q] && stage_free) begin
          load = 1'b1;
          if (bus.in_endofpacket[grant_q]) begin
            state_d      = StIdle;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Nothing is accepted while reset is held.
    if (!reset_n) begin
      in_ready = '0;
      err_sop  = 1'b0;
    end
  end

  // Output stage: load on transfer, drop valid when drained, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    chan_d      = chan_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data_arr[grant_q];
      out_sop_d   = bus.in_startofpacket[grant_q];
      out_eop_d   = bus.in_endofpacket[grant_q];
      chan_d      = grant_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= idx_t'(NUM_IN - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      chan_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      chan_q       <= chan_d;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.err_sop           = err_sop;
  assign bus.busy              = (state_q == StBusy);
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_startofpacket = out_sop_q;
  assign bus.out_endofpacket   = out_eop_q;
  assign bus.out_channel       = CHAN_W'(chan_q);

endmodule

// File: tb/tb_ik_swift_hps_st_channel_arbiter.sv
// Directed bench for the packet channel arbiter: per-source beat queues feed
// the inputs, a monitor logs accepted output beats, tasks check each scenario.
module tb_ik_swift_hps_st_channel_arbiter;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  ik_swift_hps_st_channel_arbiter_if #(.NUM_IN(4), .DATA_W(8), .CHAN_W(8)) bus ();

  ik_swift_hps_st_channel_arbiter #(.NUM_IN(4), .DATA_W(8), .CHAN_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source queues: beat = {sop, eop, data}.
  logic [9:0] mem [4][64];
  int         head [4];
  int         len [4];
  int         flush_req = 0;
  int         flush_ack = 0;

  // Accepted output beats.
  logic [7:0] rx_data [256];
  logic [7:0] rx_chan [256];
  logic       rx_sop [256];
  logic       rx_eop [256];
  int         rx_cyc [256];
  int         rx_n = 0;

  logic [3:0]  fire;
  logic [3:0]  drv_v, drv_s, drv_e;
  logic [31:0] drv_d;
  logic [9:0]  b;

  // Source driver and output monitor.
  initial begin
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      len[i]  = 0;
    end
    drv_d = '0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.in_startofpacket = '0;
    bus.in_endofpacket = '0;
    forever begin
      @(negedge clk);
      fire = bus.in_valid & bus.in_ready;
      if (bus.out_valid && bus.out_ready && rx_n < 256) begin
        rx_data[rx_n] = bus.out_data;
        rx_chan[rx_n] = bus.out_channel;
        rx_sop[rx_n]  = bus.out_startofpacket;
        rx_eop[rx_n]  = bus.out_endofpacket;
        rx_cyc[rx_n]  = cyc;
        rx_n++;
      end
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && head[i] < len[i]) head[i]++;
        if (flush_req != flush_ack) head[i] = len[i];
        if (head[i] < len[i]) begin
          b = mem[i][head[i]];
          drv_v[i] = 1'b1;
          drv_s[i] = b[9];
          drv_e[i] = b[8];
          drv_d[i*8 +: 8] = b[7:0];
        end else begin
          drv_v[i] = 1'b0;
          drv_s[i] = 1'b0;
          drv_e[i] = 1'b0;
        end
      end
      flush_ack = flush_req;
      bus.in_valid = drv_v;
      bus.in_startofpacket = drv_s;
      bus.in_endofpacket = drv_e;
      bus.in_data = drv_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input int src, input logic sop, input logic eop, input logic [7:0] d);
    mem[src][len[src]] = {sop, eop, d};
    len[src] = len[src] + 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.out_ready = 1'b1;
    flush_req++;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    enq(2, 1'b0, 1'b0, 8'h5A);
    @(negedge clk);
    total++;
    if (bus.in_ready !== 4'b0000) begin
      bad++; $display("FAIL rst_in_ready got=%b exp=0000", bus.in_ready);
    end
    total++;
    if (bus.err_sop !== 1'b0) begin
      bad++; $display("FAIL rst_err_sop got=%b exp=0", bus.err_sop);
    end
    total++;
    if ({bus.out_valid, bus.busy, bus.out_startofpacket, bus.out_endofpacket} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got=%b%b%b%b exp=0000", bus.out_valid, bus.busy,
                      bus.out_startofpacket, bus.out_endofpacket);
    end
    total++;
    if ({bus.out_data, bus.out_channel} !== 16'h0) begin
      bad++; $display("FAIL rst_data_chan got=%h/%h exp=00/00", bus.out_data, bus.out_channel);
    end
    tick();
    flush_req++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] e_rdy [6];
    logic       e_v [6];
    logic       e_b [6];
    logic [7:0] e_d [6];
    logic       e_s [6];
    logic       e_e [6];
    e_rdy = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    e_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    e_b   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e_d   = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA3};
    e_s   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    e_e   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    enq(2, 1'b1, 1'b0, 8'hA1);
    enq(2, 1'b0, 1'b0, 8'hA2);
    enq(2, 1'b0, 1'b1, 8'hA3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (bus.in_ready !== e_rdy[c]) begin
        bad++; $display("FAIL basic_in_ready c%0d got=%b exp=%b", c, bus.in_ready, e_rdy[c]);
      end
      total++;
      if (bus.out_valid !== e_v[c]) begin
        bad++; $display("FAIL basic_out_valid c%0d got=%b exp=%b", c, bus.out_valid, e_v[c]);
      end
      total++;
      if (bus.busy !== e_b[c]) begin
        bad++; $display("FAIL basic_busy c%0d got=%b exp=%b", c, bus.busy, e_b[c]);
      end
      if (c >= 2 && c <= 4) begin
        total++;
        if ({bus.out_data, bus.out_channel, bus.out_startofpacket, bus.out_endofpacket} !==
            {e_d[c], 8'd2, e_s[c], e_e[c]}) begin
          bad++;
          $display("FAIL basic_beat c%0d got=%h/%h/%b%b exp=%h/02/%b%b", c, bus.out_data,
                   bus.out_channel, bus.out_startofpacket, bus.out_endofpacket,
                   e_d[c], e_s[c], e_e[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] e_ch [10];
    logic [7:0] e_d [10];
    int base;
    e_ch = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd0, 8'd0};
    e_d  = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    do_reset();
    base = rx_n;
    for (int i = 0; i < 4; i++) begin
      enq(i, 1'b1, 1'b0, {i[3:0], 4'h0});
      enq(i, 1'b0, 1'b1, {i[3:0], 4'h1});
    end
    enq(0, 1'b1, 1'b0, 8'h02);
    enq(0, 1'b0, 1'b1, 8'h03);
    for (int k = 0; k < 100 && (rx_n - base) < 10; k++) tick();
    tick();
    total++;
    if (rx_n - base !== 10) begin
      bad++; $display("FAIL rr_count got=%0d exp=10", rx_n - base);
    end
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({rx_chan[base+k], rx_data[base+k], rx_sop[base+k], rx_eop[base+k]} !==
          {e_ch[k], e_d[k], (k % 2 == 0), (k % 2 == 1)}) begin
        bad++;
        $display("FAIL rr_beat%0d got=ch%0d/%h/%b%b exp=ch%0d/%h", k, rx_chan[base+k],
                 rx_data[base+k], rx_sop[base+k], rx_eop[base+k], e_ch[k], e_d[k]);
      end
    end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (rx_cyc[base+k+1] - rx_cyc[base+k] !== ((k % 2 == 1) ? 2 : 1)) begin
        bad++;
        $display("FAIL rr_gap%0d got=%0d exp=%0d", k, rx_cyc[base+k+1] - rx_cyc[base+k],
                 (k % 2 == 1) ? 2 : 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    do_reset();
    base = rx_n;
    enq(0, 1'b1, 1'b0, 8'hC0);
    enq(0, 1'b0, 1'b0, 8'hC1);
    enq(0, 1'b0, 1'b0, 8'hC2);
    enq(0, 1'b0, 1'b1, 8'hC3);
    tick();
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.out_data, bus.in_ready} !== {1'b1, 8'hC1, 4'b0000}) begin
        bad++;
        $display("FAIL bp_hold c%0d got=v%b/%h/rdy%b exp=v1/c1/rdy0000", c, bus.out_valid,
                 bus.out_data, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    total++;
    if (rx_n - base !== 4) begin
      bad++; $display("FAIL bp_count got=%0d exp=4", rx_n - base);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rx_data[base+k] !== 8'hC0 + 8'(k)) begin
        bad++; $display("FAIL bp_beat%0d got=%h exp=%h", k, rx_data[base+k], 8'hC0 + 8'(k));
      end
    end
  endtask

  task automatic test_no_interleave();
    int base;
    do_reset();
    base = rx_n;
    for (int k = 0; k < 6; k++) enq(0, (k == 0), (k == 5), 8'h50 + 8'(k));
    tick();
    tick();
    enq(1, 1'b1, 1'b0, 8'h60);
    enq(1, 1'b0, 1'b1, 8'h61);
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if (bus.in_ready[1] !== (c == 8)) begin
        bad++; $display("FAIL ni_rdy1 c%0d got=%b exp=%b", c, bus.in_ready[1], (c == 8));
      end
      tick();
    end
    for (int k = 0; k < 8; k++) tick();
    total++;
    if (rx_n - base !== 8) begin
      bad++; $display("FAIL ni_count got=%0d exp=8", rx_n - base);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({rx_chan[base+k], rx_data[base+k]} !==
          {((k < 6) ? 8'd0 : 8'd1), ((k < 6) ? 8'h50 + 8'(k) : 8'h60 + 8'(k - 6))}) begin
        bad++; $display("FAIL ni_beat%0d got=ch%0d/%h", k, rx_chan[base+k], rx_data[base+k]);
      end
    end
  endtask

  task automatic test_err_sop();
    logic [3:0] e_rdy [4];
    logic       e_err [4];
    logic       e_v [4];
    logic       e_b [4];
    e_rdy = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
    e_err = '{1'b1, 1'b0, 1'b0, 1'b0};
    e_v   = '{1'b0, 1'b0, 1'b0, 1'b1};
    e_b   = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    enq(3, 1'b0, 1'b0, 8'hEE);
    enq(3, 1'b1, 1'b1, 8'h77);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({bus.in_ready, bus.err_sop, bus.out_valid, bus.busy} !==
          {e_rdy[c], e_err[c], e_v[c], e_b[c]}) begin
        bad++;
        $display("FAIL err c%0d got=rdy%b err%b v%b busy%b exp=rdy%b err%b v%b busy%b", c,
                 bus.in_ready, bus.err_sop, bus.out_valid, bus.busy,
                 e_rdy[c], e_err[c], e_v[c], e_b[c]);
      end
      if (c == 3) begin
        total++;
        if ({bus.out_data, bus.out_channel, bus.out_startofpacket, bus.out_endofpacket} !==
            {8'h77, 8'd3, 1'b1, 1'b1}) begin
          bad++;
          $display("FAIL err_beat got=%h/%h/%b%b exp=77/03/11", bus.out_data, bus.out_channel,
                   bus.out_startofpacket, bus.out_endofpacket);
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    for (int k = 0; k < 4; k++) enq(1, (k == 0), (k == 3), 8'h90 + 8'(k));
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    flush_req++;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 4'b0000) begin
      bad++; $display("FAIL mr_rdy_in_reset got=%b exp=0000", bus.in_ready);
    end
    tick();
    reset_n = 1'b1;
    base = rx_n;
    enq(0, 1'b1, 1'b1, 8'hA0);
    enq(1, 1'b1, 1'b1, 8'hB0);
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_channel, bus.out_startofpacket,
         bus.out_endofpacket, bus.busy, bus.err_sop} !== 21'h0) begin
      bad++;
      $display("FAIL mr_cleared got=v%b %h/%h %b%b busy%b err%b", bus.out_valid, bus.out_data,
               bus.out_channel, bus.out_startofpacket, bus.out_endofpacket, bus.busy,
               bus.err_sop);
    end
    for (int k = 0; k < 10; k++) tick();
    total++;
    if (rx_n - base !== 2) begin
      bad++; $display("FAIL mr_count got=%0d exp=2", rx_n - base);
    end
    total++;
    if ({rx_chan[base], rx_data[base], rx_chan[base+1], rx_data[base+1]} !==
        {8'd0, 8'hA0, 8'd1, 8'hB0}) begin
      bad++;
      $display("FAIL mr_order got=ch%0d/%h ch%0d/%h exp=ch0/a0 ch1/b0", rx_chan[base],
               rx_data[base], rx_chan[base+1], rx_data[base+1]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_no_interleave();
    test_err_sop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
